hwpe_stream_sink_strided: RTL and testbench
===========================================

HWPE_STREAM_SINK_STRIDED -- requirements
Module: hwpe_stream_sink_strided

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: stream data width in bits; multiple of 32.
REQ-002 SHALL have parameter NB_TCDM_PORTS, default DATA_WIDTH/32: number of 32-bit TCDM write ports.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: TCDM byte-address width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the length and index counters.
REQ-005 SHALL have port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port clear_i, input, 1: synchronous soft abort.
REQ-008 SHALL have port start_i, input, 1: transfer start request.
REQ-009 SHALL have ports base_addr_i (ADDR_WIDTH), stride0_i (ADDR_WIDTH), stride1_i (ADDR_WIDTH), all inputs: base byte address, inner stride, outer stride.
REQ-010 SHALL have ports len0_i and len1_i, inputs, CNT_WIDTH each: inner beat count and outer row count.
REQ-011 SHALL have stream sink ports stream_valid_i (1), stream_ready_o (1), stream_data_i (DATA_WIDTH), stream_strb_i (DATA_WIDTH/8).
REQ-012 SHALL have TCDM master ports tcdm_req_o (NB_TCDM_PORTS), tcdm_gnt_i (NB_TCDM_PORTS), tcdm_wen_o (NB_TCDM_PORTS), tcdm_add_o (NB_TCDM_PORTS*ADDR_WIDTH), tcdm_be_o (NB_TCDM_PORTS*4), tcdm_data_o (NB_TCDM_PORTS*32); port ii uses slice ii.
REQ-013 SHALL have status outputs ready_start_o, busy_o, done_o, 1 bit each.

Function
REQ-014 SHALL implement FSM states IDLE and WORKING; ready_start_o = (state==IDLE); busy_o = (state==WORKING).
REQ-015 In IDLE with start_i=1, SHALL latch all config inputs, zero indices j0/j1, set cur_addr = row_addr = base_addr_i, and enter WORKING next cycle.
REQ-016 If len0_i==0 or len1_i==0 at start, SHALL return to IDLE after 1 WORKING cycle, issue no TCDM request, and pulse done_o.
REQ-017 start_i while WORKING SHALL be ignored; latched config SHALL not change.
REQ-018 In WORKING, port ii SHALL assert tcdm_req_o[ii] = stream_valid_i & ~granted[ii], where granted is a per-port sticky mask of ports already granted in the current beat.
REQ-019 tcdm_add_o[ii] SHALL equal cur_addr + 4*ii modulo 2^ADDR_WIDTH; tcdm_wen_o SHALL be all 0 (write); tcdm_be_o[ii] = stream_strb_i[4*ii+3:4*ii]; tcdm_data_o[ii] = stream_data_i[32*ii+31:32*ii].
REQ-020 stream_ready_o SHALL be 1 only in WORKING when (granted | tcdm_gnt_i) is all ones and stream_valid_i=1; this is beat completion.
REQ-021 On beat completion, granted SHALL clear; otherwise granted |= tcdm_req_o & tcdm_gnt_i.
REQ-022 On beat completion with j0 < len0-1: j0++, cur_addr += stride0.
REQ-023 On beat completion with j0 == len0-1 and j1 < len1-1: j0=0, j1++, row_addr += stride1, cur_addr = row_addr + stride1.
REQ-024 On beat completion with j0 == len0-1 and j1 == len1-1: SHALL enter IDLE and assert done_o for exactly the next cycle.
REQ-025 All address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; strides are unsigned.
REQ-026 In IDLE, tcdm_req_o and stream_ready_o SHALL be 0.
REQ-027 A port that is granted SHALL not re-request within the same beat; ungranted ports SHALL hold req with stable address and data.
REQ-028 clear_i SHALL force IDLE, zero granted/j0/j1, and suppress done_o in the same edge; clear_i has priority over start_i and beat completion.
REQ-029 Upstream SHALL hold stream_data_i/strb stable while valid & ~ready; the block does not buffer data.

Reset
REQ-030 On rst_i=1 at a clock edge, the block SHALL enter IDLE with granted, j0, j1, cur_addr, row_addr zero; rst_i has priority over clear_i.
REQ-031 During and after reset: tcdm_req_o=0, stream_ready_o=0, done_o=0, busy_o=0, ready_start_o=1.

Verification
REQ-032 1D: base=0x100, stride0=8, len0=4, len1=1, NB=2, gnt always 1, valid always 1 -> addresses 0x100/0x104, 0x108/0x10C, 0x110/0x114, 0x118/0x11C on 4 consecutive cycles; done_o pulses once, 1 cycle after the last beat.
REQ-033 2D: base=0x0, stride0=8, len0=2, stride1=0x40, len1=2 -> beat addresses 0x0, 0x8, 0x40, 0x48.
REQ-034 Partial grant: port0 gnt in cycle 1, port1 gnt in cycle 3 -> port0 req drops after cycle 1; stream_ready_o=1 only in cycle 3; address unchanged across cycles 1-3.
REQ-035 Zero length: len0=0 -> no tcdm_req_o, done_o pulses once, return to IDLE.
REQ-036 clear_i mid-transfer (beat 2 of 4) -> IDLE next cycle, no done_o; new start with base=0x200 issues 0x200 first.
REQ-037 rst_i asserted mid-transfer -> all outputs at REQ-031 values next cycle; address wrap: base=0xFFFFFFF8, stride0=8, len0=2 -> second beat address 0x0.

Source files
------------

// File: rtl/hwpe_stream_sink_strided.sv
// hwpe_stream_sink_strided: writes a 2D strided stream of beats to TCDM over NB_TCDM_PORTS 32-bit ports
module hwpe_stream_sink_strided #(
   parameter int DATA_WIDTH    = 64,
   parameter int NB_TCDM_PORTS = DATA_WIDTH/32,
   parameter int ADDR_WIDTH    = 32,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clear_i,
   input  logic                                start_i,
   input  logic [ADDR_WIDTH-1:0]               base_addr_i,
   input  logic [ADDR_WIDTH-1:0]               stride0_i,
   input  logic [ADDR_WIDTH-1:0]               stride1_i,
   input  logic [CNT_WIDTH-1:0]                len0_i,
   input  logic [CNT_WIDTH-1:0]                len1_i,
   input  logic                                stream_valid_i,
   output logic                                stream_ready_o,
   input  logic [DATA_WIDTH-1:0]               stream_data_i,
   input  logic [DATA_WIDTH/8-1:0]             stream_strb_i,
   output logic [NB_TCDM_PORTS-1:0]            tcdm_req_o,
   input  logic [NB_TCDM_PORTS-1:0]            tcdm_gnt_i,
   output logic [NB_TCDM_PORTS-1:0]            tcdm_wen_o,
   output logic [NB_TCDM_PORTS*ADDR_WIDTH-1:0] tcdm_add_o,
   output logic [NB_TCDM_PORTS*4-1:0]          tcdm_be_o,
   output logic [NB_TCDM_PORTS*32-1:0]         tcdm_data_o,
   output logic                                ready_start_o,
   output logic                                busy_o,
   output logic                                done_o
);
   typedef enum logic {IDLE, WORKING} state_t;
   state_t                   state_q, state_d;
   logic [NB_TCDM_PORTS-1:0] granted_q, granted_d;
   logic [CNT_WIDTH-1:0]     j0_q, j0_d, j1_q, j1_d, len0_q, len0_d, len1_q, len1_d;
   logic [ADDR_WIDTH-1:0]    cur_q, cur_d, row_q, row_d, stride0_q, stride0_d, stride1_q, stride1_d;
   logic                     zero_q, zero_d, done_q, done_d;
   logic                     active, beat_done;
   assign active         = (state_q == WORKING) & ~zero_q & stream_valid_i;
   assign tcdm_req_o     = {NB_TCDM_PORTS{active}} & ~granted_q;
   assign beat_done      = active & (&(granted_q | tcdm_gnt_i));
   assign stream_ready_o = beat_done;
   assign tcdm_wen_o     = '0;
   assign ready_start_o  = state_q == IDLE;
   assign busy_o         = state_q == WORKING;
   assign done_o         = done_q;
   for (genvar i = 0; i < NB_TCDM_PORTS; i++) begin : g_port
      assign tcdm_add_o[i*ADDR_WIDTH +: ADDR_WIDTH] = cur_q + ADDR_WIDTH'(4*i);
      assign tcdm_be_o[i*4 +: 4]                    = stream_strb_i[i*4 +: 4];
      assign tcdm_data_o[i*32 +: 32]                = stream_data_i[i*32 +: 32];
   end
   // next state: config latch on start, grant tracking, 2D index/address walk, done pulse
   always_comb begin
      state_d   = state_q;
      granted_d = granted_q;
      j0_d      = j0_q;
      j1_d      = j1_q;
      len0_d    = len0_q;
      len1_d    = len1_q;
      cur_d     = cur_q;
      row_d     = row_q;
      stride0_d = stride0_q;
      stride1_d = stride1_q;
      zero_d    = zero_q;
      done_d    = 1'b0;
      if (clear_i) begin
         state_d   = IDLE;
         granted_d = '0;
         j0_d      = '0;
         j1_d      = '0;
      end else if (state_q == IDLE) begin
         if (start_i) begin
            state_d   = WORKING;
            granted_d = '0;
            j0_d      = '0;
            j1_d      = '0;
            len0_d    = len0_i;
            len1_d    = len1_i;
            stride0_d = stride0_i;
            stride1_d = stride1_i;
            cur_d     = base_addr_i;
            row_d     = base_addr_i;
            zero_d    = (len0_i == '0) | (len1_i == '0);
         end
      end else if (zero_q) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end else if (beat_done) begin
         granted_d = '0;
         if (j0_q < len0_q - CNT_WIDTH'(1)) begin
            j0_d  = j0_q + CNT_WIDTH'(1);
            cur_d = cur_q + stride0_q;
         end else if (j1_q < len1_q - CNT_WIDTH'(1)) begin
            j0_d  = '0;
            j1_d  = j1_q + CNT_WIDTH'(1);
            row_d = row_q + stride1_q;
            cur_d = row_q + stride1_q;
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else begin
         granted_d = granted_q | (tcdm_req_o & tcdm_gnt_i);
      end
   end
   // state register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         granted_q <= '0;
         j0_q      <= '0;
         j1_q      <= '0;
         len0_q    <= '0;
         len1_q    <= '0;
         cur_q     <= '0;
         row_q     <= '0;
         stride0_q <= '0;
         stride1_q <= '0;
         zero_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         granted_q <= granted_d;
         j0_q      <= j0_d;
         j1_q      <= j1_d;
         len0_q    <= len0_d;
         len1_q    <= len1_d;
         cur_q     <= cur_d;
         row_q     <= row_d;
         stride0_q <= stride0_d;
         stride1_q <= stride1_d;
         zero_q    <= zero_d;
         done_q    <= done_d;
      end
   end
endmodule

// File: tb/tb_hwpe_stream_sink_strided.sv
// tb_hwpe_stream_sink_strided: directed and random transfers checked against an address-list model
module tb_hwpe_stream_sink_strided;
   localparam int DW = 64, NB = 2, AW = 32, CW = 16;
   logic clk = 1'b0;
   logic rst, clear, start, valid, ready, ready_start, busy, done;
   logic [AW-1:0] base_addr, stride0, stride1;
   logic [CW-1:0] len0, len1;
   logic [DW-1:0] sdata;
   logic [DW/8-1:0] strb;
   logic [NB-1:0] req, gnt, wen;
   logic [NB*AW-1:0] add;
   logic [NB*4-1:0] be;
   logic [NB*32-1:0] tdata;
   int n_cmp = 0, n_err = 0;
   int cyc;

   hwpe_stream_sink_strided #(.DATA_WIDTH(DW), .NB_TCDM_PORTS(NB), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
      .base_addr_i(base_addr), .stride0_i(stride0), .stride1_i(stride1),
      .len0_i(len0), .len1_i(len1),
      .stream_valid_i(valid), .stream_ready_o(ready), .stream_data_i(sdata), .stream_strb_i(strb),
      .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_wen_o(wen), .tcdm_add_o(add),
      .tcdm_be_o(be), .tcdm_data_o(tdata),
      .ready_start_o(ready_start), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag, input logic exp_done);
      chk({tag, "_req"}, req, '0);
      chk({tag, "_ready"}, ready, 1'b0);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_rstart"}, ready_start, 1'b1);
   endtask

   task automatic begin_xfer(input logic [AW-1:0] b, s0, s1, input int l0, l1);
      @(negedge clk);
      base_addr = b; stride0 = s0; stride1 = s1; len0 = CW'(l0); len1 = CW'(l1);
      start = 1'b1; valid = 1'b0; gnt = '0; clear = 1'b0;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("busy_after_start", busy, 1'b1);
      chk("rstart_after_start", ready_start, 1'b0);
   endtask

   // full transfer; expected beat addresses come from base + j1*stride1 + j0*stride0
   task automatic xfer(input logic [AW-1:0] b, s0, s1, input int l0, l1, gp, vp, output int ncyc);
      logic [AW-1:0] exp_addr[$];
      logic [NB-1:0] gm, g, ereq;
      logic [DW-1:0] d;
      logic [DW/8-1:0] sb;
      logic v, erdy;
      int beat;
      for (int r = 0; r < l1; r++)
         for (int c = 0; c < l0; c++)
            exp_addr.push_back(b + AW'(r) * s1 + AW'(c) * s0);
      begin_xfer(b, s0, s1, l0, l1);
      beat = 0; gm = '0; v = 1'b0; ncyc = 0; d = '0; sb = '0;
      if (exp_addr.size() == 0) begin
         valid = 1'b1; gnt = '1;
         #1;
         chk("zero_req", req, '0);
         chk("zero_ready", ready, 1'b0);
         @(negedge clk);
      end
      while (beat < exp_addr.size() && ncyc < 2000) begin
         if (!v) begin
            v = $urandom_range(99) < vp;
            d = {$urandom, $urandom};
            sb = DW/8'($urandom);
         end
         for (int i = 0; i < NB; i++) g[i] = $urandom_range(99) < gp;
         valid = v; sdata = d; strb = sb; gnt = g;
         start = 1'($urandom_range(1)); base_addr = $urandom; stride0 = $urandom; len0 = CW'($urandom);
         #1;
         ereq = {NB{v}} & ~gm;
         erdy = v && (&(gm | g));
         chk("req", req, ereq);
         chk("ready", ready, erdy);
         chk("wen", wen, '0);
         chk("busy", busy, 1'b1);
         if (v)
            for (int i = 0; i < NB; i++) begin
               chk("addr", add[i*AW +: AW], exp_addr[beat] + AW'(4*i));
               chk("be", be[i*4 +: 4], sb[i*4 +: 4]);
               chk("data", tdata[i*32 +: 32], d[i*32 +: 32]);
            end
         @(posedge clk);
         if (erdy) begin beat++; gm = '0; v = 1'b0; end
         else gm |= ereq & g;
         ncyc++;
         @(negedge clk);
      end
      if (ncyc >= 2000) chk("cycle_budget", 1'b1, 1'b0);
      valid = 1'b0; start = 1'b0; gnt = '0;
      #1;
      idle_chk("end", 1'b1);
      @(negedge clk);
      #1;
      chk("done_once", done, 1'b0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; start = 1'b0; valid = 1'b1; gnt = '1;
      base_addr = '0; stride0 = '0; stride1 = '0; len0 = '0; len1 = '0; sdata = '0; strb = '0;
      @(negedge clk); @(negedge clk);
      #1;
      idle_chk("reset", 1'b0);
      rst = 1'b0; valid = 1'b0;
      // 1D, full grant, always valid: 4 consecutive beats
      xfer(32'h100, 32'h8, 32'h0, 4, 1, 100, 100, cyc);
      chk("1d_cycles", cyc, 4);
      // 2D
      xfer(32'h0, 32'h8, 32'h40, 2, 2, 100, 100, cyc);
      chk("2d_cycles", cyc, 4);
      // zero length in either dimension
      xfer(32'h80, 32'h8, 32'h40, 0, 3, 100, 100, cyc);
      xfer(32'h80, 32'h8, 32'h40, 3, 0, 100, 100, cyc);
      // address wrap
      xfer(32'hFFFF_FFF8, 32'h8, 32'h0, 2, 1, 100, 100, cyc);
      // partial grant: port0 in cycle 1, nothing in cycle 2, port1 in cycle 3
      begin_xfer(32'h40, 32'h8, 32'h0, 1, 1);
      valid = 1'b1; sdata = 64'h1122_3344_5566_7788; strb = 8'hA5; gnt = 2'b01;
      #1;
      chk("pg1_req", req, 2'b11); chk("pg1_ready", ready, 1'b0); chk("pg1_addr", add, {32'h44, 32'h40});
      @(negedge clk); gnt = 2'b00; #1;
      chk("pg2_req", req, 2'b10); chk("pg2_ready", ready, 1'b0); chk("pg2_addr", add, {32'h44, 32'h40});
      @(negedge clk); gnt = 2'b10; #1;
      chk("pg3_req", req, 2'b10); chk("pg3_ready", ready, 1'b1); chk("pg3_addr", add, {32'h44, 32'h40});
      @(negedge clk); valid = 1'b0; gnt = '0; #1;
      idle_chk("pg_end", 1'b1);
      // clear during beat 2 of 4
      begin_xfer(32'h300, 32'h8, 32'h0, 4, 1);
      valid = 1'b1; gnt = '1; #1;
      chk("clr_beat1", add[AW-1:0], 32'h300);
      @(negedge clk); #1;
      chk("clr_beat2", add[AW-1:0], 32'h308);
      clear = 1'b1; start = 1'b1;
      @(negedge clk); clear = 1'b0; start = 1'b0; #1;
      idle_chk("clr_idle", 1'b0);
      @(negedge clk); #1;
      idle_chk("clr_nodone", 1'b0);
      valid = 1'b0;
      xfer(32'h200, 32'h4, 32'h0, 2, 1, 100, 100, cyc);
      // reset mid-transfer
      begin_xfer(32'h500, 32'h8, 32'h0, 4, 2);
      valid = 1'b1; gnt = '1;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); #1;
      idle_chk("rst_mid", 1'b0);
      rst = 1'b0; valid = 1'b0;
      // random transfers with random valid and grant patterns
      for (int k = 0; k < 8; k++)
         xfer($urandom, AW'($urandom_range(0, 64)) * 4, AW'($urandom_range(0, 64)) * 4,
              $urandom_range(1, 4), $urandom_range(1, 3), 50, 70, cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
